// File: rtl/muldiv_if.sv
// muldiv_if: EX-stage request/response bundle between the pipeline and the M-extension sequencer
interface muldiv_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  modport master (output start, funct3, op_a, op_b, flush, input stall, busy, done, result);
  modport slave  (input start, funct3, op_a, op_b, flush, output stall, busy, done, result);
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer; shift-add multiply, restoring divide, sign fix-up
module muldiv_seq #(parameter int XLEN = 32) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(XLEN) + 1;
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
  state_t            state;
  logic [2:0]        f3;
  logic              sgn;
  logic [XLEN-1:0]   mcand;
  logic [2*XLEN-1:0] prod;
  logic [XLEN:0]     rem;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   res;
  logic              a_signed, b_signed, sa, sb, div_zero, div_ovf;
  logic [XLEN-1:0]   ma, mb, special, q_fix, r_fix, pick;
  logic [XLEN:0]     sum, sh, diff;
  logic [2*XLEN-1:0] prod_fix;
  always_comb begin
    a_signed = ~bus.funct3[0] | (bus.funct3 == 3'b001);
    b_signed = a_signed & (bus.funct3 != 3'b010);
    sa = a_signed & bus.op_a[XLEN-1];
    sb = b_signed & bus.op_b[XLEN-1];
    ma = sa ? -bus.op_a : bus.op_a;
    mb = sb ? -bus.op_b : bus.op_b;
    div_zero = bus.funct3[2] & ~|bus.op_b;
    div_ovf = bus.funct3[2] & ~bus.funct3[0] & (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.op_b);
    special = div_zero ? (bus.funct3[1] ? bus.op_a : '1) : (bus.funct3[1] ? '0 : bus.op_a);
    sum = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
    sh = {rem[XLEN-1:0], prod[XLEN-1]};
    diff = sh - {1'b0, mcand};
    prod_fix = sgn ? -prod : prod;
    q_fix = sgn ? -prod[XLEN-1:0] : prod[XLEN-1:0];
    r_fix = XLEN'(sgn ? -rem : rem);
    pick = (f3 == 3'b000) ? prod_fix[XLEN-1:0] : ~f3[2] ? prod_fix[2*XLEN-1:XLEN] : f3[1] ? r_fix : q_fix;
  end
  // prod low half holds the multiplier (MUL) or the dividend/quotient (DIV); mcand holds the other operand
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      f3 <= '0;
      sgn <= 1'b0;
      mcand <= '0;
      prod <= '0;
      rem <= '0;
      cnt <= '0;
      res <= '0;
    end else if (bus.flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          f3 <= bus.funct3;
          sgn <= (bus.funct3[2] & bus.funct3[1]) ? sa : sa ^ sb;
          mcand <= bus.funct3[2] ? mb : ma;
          prod <= {{XLEN{1'b0}}, bus.funct3[2] ? ma : mb};
          rem <= '0;
          cnt <= '0;
          if (div_zero | div_ovf) begin
            res <= special;
            state <= DONE;
          end else begin
            state <= bus.funct3[2] ? DIV : MUL;
          end
        end
        MUL: begin
          prod <= {sum, prod[XLEN-1:1]};
          cnt <= cnt + 1'b1;
          state <= (cnt == CW'(XLEN-1)) ? FIX : MUL;
        end
        DIV: begin
          rem <= diff[XLEN] ? sh : diff;
          prod[XLEN-1:0] <= {prod[XLEN-2:0], ~diff[XLEN]};
          cnt <= cnt + 1'b1;
          state <= (cnt == CW'(XLEN-1)) ? FIX : DIV;
        end
        FIX: begin
          res <= pick;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.result = res;
  assign bus.stall = bus.start & ~bus.done & ~bus.flush;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed scoreboard bench for the RV32M multiply/divide sequencer
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  muldiv_if #(.XLEN(32)) bus();
  muldiv_seq #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_res = '0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask
  // called at a negedge; lat counts the request cycle through the done cycle
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
    int n;
    sb_q.push_back(exp);
    bus.start = 1'b1;
    bus.funct3 = f;
    bus.op_a = a;
    bus.op_b = b;
    #1;
    chk({tag, ".stall"}, 32'(bus.stall), 32'd1);
    wait_done(n);
    chk({tag, ".lat"}, 32'(n + 1), 32'(lat));
    chk({tag, ".res"}, bus.result, sb_q.pop_front());
    chk({tag, ".stall_done"}, 32'(bus.stall), 32'd0);
    last_res = exp;
    bus.start = 1'b0;
    @(negedge clk);
    chk({tag, ".pulse"}, 32'(bus.done), 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    int n, c1, c2;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.funct3 = '0;
    bus.op_a = '0;
    bus.op_b = '0;
    #12;
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    chk("rst.result", bus.result, 32'd0);
    chk("rst.stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("mul_7x6",     3'b000, 32'd7,        32'd6,        32'd42,       35);
    run_op("mulhu_ff",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 35);
    run_op("mul_ff",      3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 35);
    run_op("mulh_m1x2",   3'b001, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 35);
    run_op("mulhsu_m1x2", 3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 35);
    run_op("mulhu_x2",    3'b011, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 35);
    run_op("mulh_min2",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 35);
    run_op("div_m7_2",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 35);
    run_op("rem_m7_2",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 35);
    run_op("div_7_m2",    3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 35);
    run_op("rem_7_m2",    3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, 35);
    run_op("divu_100_7",  3'b101, 32'd100,      32'd7,        32'd14,       35);
    run_op("remu_100_7",  3'b111, 32'd100,      32'd7,        32'd2,        35);
    run_op("divu_max_1",  3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 35);
    run_op("div_by0",     3'b100, 32'h12345678, 32'd0,        32'hFFFFFFFF, 2);
    run_op("remu_by0",    3'b111, 32'h12345678, 32'd0,        32'h12345678, 2);
    run_op("div_ovf",     3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
    run_op("rem_ovf",     3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2);
    // flush at iteration 10 of a DIV
    bus.start = 1'b1;
    bus.funct3 = 3'b100;
    bus.op_a = 32'd100;
    bus.op_b = 32'd7;
    repeat (11) @(negedge clk);
    bus.flush = 1'b1;
    #1;
    chk("flush.stall", 32'(bus.stall), 32'd0);
    chk("flush.busy_before", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("flush.busy", 32'(bus.busy), 32'd0);
    chk("flush.done", 32'(bus.done), 32'd0);
    chk("flush.result", bus.result, last_res);
    bus.flush = 1'b0;
    run_op("after_flush", 3'b111, 32'd100, 32'd7, 32'd2, 35);
    // async reset in the middle of a MUL
    bus.start = 1'b1;
    bus.funct3 = 3'b000;
    bus.op_a = 32'd3;
    bus.op_b = 32'd5;
    repeat (21) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst.busy", 32'(bus.busy), 32'd0);
    chk("midrst.done", 32'(bus.done), 32'd0);
    chk("midrst.result", bus.result, 32'd0);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    last_res = '0;
    @(negedge clk);
    // start held across two back-to-back ops
    sb_q.push_back(32'd42);
    sb_q.push_back(32'd14);
    bus.start = 1'b1;
    bus.funct3 = 3'b000;
    bus.op_a = 32'd7;
    bus.op_b = 32'd6;
    wait_done(n);
    c1 = cyc;
    chk("b2b.res1", bus.result, sb_q.pop_front());
    bus.funct3 = 3'b101;
    bus.op_a = 32'd100;
    bus.op_b = 32'd7;
    @(negedge clk);
    chk("b2b.pulse1", 32'(bus.done), 32'd0);
    wait_done(n);
    c2 = cyc;
    chk("b2b.gap", 32'(c2 - c1), 32'd35);
    chk("b2b.res2", bus.result, sb_q.pop_front());
    bus.start = 1'b0;
    @(negedge clk);
    chk("b2b.pulse2", 32'(bus.done), 32'd0);
    chk("b2b.idle", 32'(bus.busy), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
